// File: rtl/mips_cpu_pkg.sv
// Shared widths and the writeback payload type for the MIPS writeback stage.
package mips_cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_GPR    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  // One pending register-file write: destination GPR and its value.
  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/mips_cpu_writeback_if.sv
// Bundle of issue, result and register-file write signals around the writeback stage.
interface mips_cpu_writeback_if;
  import mips_cpu_pkg::*;

  logic      issue_valid;
  reg_addr_t issue_rd;
  logic      issue_stall;
  reg_addr_t src_rs;
  reg_addr_t src_rt;
  logic      hazard;
  logic      alu_valid;
  reg_addr_t alu_rd;
  reg_data_t alu_data;
  logic      mem_valid;
  reg_addr_t mem_rd;
  reg_data_t mem_data;
  logic      mem_ready;
  logic      Regwrite;
  reg_addr_t write_register;
  reg_data_t write_data;
  logic      spurious_wb;

  // Pipeline side: issues instructions and delivers results.
  modport master (
    output issue_valid, issue_rd, src_rs, src_rt,
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_stall, hazard, mem_ready,
    input  Regwrite, write_register, write_data, spurious_wb
  );

  // Writeback stage side.
  modport slave (
    input  issue_valid, issue_rd, src_rs, src_rt,
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_stall, hazard, mem_ready,
    output Regwrite, write_register, write_data, spurious_wb
  );

endinterface

// File: rtl/mips_cpu_wb_fifo.sv
// In-order buffer for load results waiting for a free writeback slot.
module mips_cpu_wb_fifo
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push, do_pop;

  // Next pointer and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    head     = mem_q[rd_ptr_q];
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage.
  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mips_cpu_writeback.sv
// Writeback stage: GPR busy scoreboard, ALU-over-load arbitration, registered RF write port.
module mips_cpu_writeback
  import mips_cpu_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  output logic      issue_stall,
  input  reg_addr_t src_rs,
  input  reg_addr_t src_rt,
  output logic      hazard,
  input  logic      alu_valid,
  input  reg_addr_t alu_rd,
  input  reg_data_t alu_data,
  input  logic      mem_valid,
  input  reg_addr_t mem_rd,
  input  reg_data_t mem_data,
  output logic      mem_ready,
  output logic      Regwrite,
  output reg_addr_t write_register,
  output reg_data_t write_data,
  output logic      spurious_wb
);

  logic [NUM_GPR-1:0] busy_q, busy_d;
  logic               regwrite_q, regwrite_d;
  reg_addr_t          write_register_q, write_register_d;
  reg_data_t          write_data_q, write_data_d;
  logic               spurious_q, spurious_d;

  wb_entry_t fifo_head, sel;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop, sel_valid;

  mips_cpu_wb_fifo #(.DEPTH(MEM_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data ({mem_rd, mem_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Hazard flags, load handshake, writeback selection and scoreboard update.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    issue_stall = issue_valid & busy_q[issue_rd];
    hazard      = busy_q[src_rs] | busy_q[src_rt];
    mem_ready   = reset & ~fifo_full;
    fifo_push   = mem_valid & mem_ready;
    fifo_pop    = reset & ~alu_valid & ~fifo_empty;
    sel_valid   = alu_valid | ~fifo_empty;
    sel         = alu_valid ? wb_entry_t'({alu_rd, alu_data}) : fifo_head;

    regwrite_d       = sel_valid && (sel.rd != '0);
    write_register_d = sel_valid ? sel.rd   : write_register_q;
    write_data_d     = sel_valid ? sel.data : write_data_q;
    spurious_d       = spurious_q | (regwrite_d & ~busy_q[sel.rd]);

    // Clear of the retiring writer first, then a new issue to the same GPR overrides it.
    busy_d = busy_q;
    if (regwrite_d) busy_d[sel.rd] = 1'b0;
    if (issue_valid && !issue_stall && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops buffered and in-flight results without a write pulse.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q           <= '0;
      regwrite_q       <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      spurious_q       <= 1'b0;
    end else begin
      busy_q           <= busy_d;
      regwrite_q       <= regwrite_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      spurious_q       <= spurious_d;
    end
  end

  assign Regwrite       = regwrite_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign spurious_wb    = spurious_q;

endmodule

// File: tb/tb_mips_cpu_writeback.sv
// Directed bench for mips_cpu_writeback with an expected-write scoreboard.
module tb_mips_cpu_writeback;
  import mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_writeback_if wbif ();

  mips_cpu_writeback #(.MEM_FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (wbif.issue_valid),
    .issue_rd       (wbif.issue_rd),
    .issue_stall    (wbif.issue_stall),
    .src_rs         (wbif.src_rs),
    .src_rt         (wbif.src_rt),
    .hazard         (wbif.hazard),
    .alu_valid      (wbif.alu_valid),
    .alu_rd         (wbif.alu_rd),
    .alu_data       (wbif.alu_data),
    .mem_valid      (wbif.mem_valid),
    .mem_rd         (wbif.mem_rd),
    .mem_data       (wbif.mem_data),
    .mem_ready      (wbif.mem_ready),
    .Regwrite       (wbif.Regwrite),
    .write_register (wbif.write_register),
    .write_data     (wbif.write_data),
    .spurious_wb    (wbif.spurious_wb)
  );

  int        total = 0;
  int        bad   = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wbif.issue_valid = 1'b0; wbif.issue_rd = '0;
    wbif.alu_valid   = 1'b0; wbif.alu_rd   = '0; wbif.alu_data = '0;
    wbif.mem_valid   = 1'b0; wbif.mem_rd   = '0; wbif.mem_data = '0;
  endtask

  task automatic issue(input reg_addr_t rd);
    wbif.issue_valid = 1'b1;
    wbif.issue_rd    = rd;
    tick();
    wbif.issue_valid = 1'b0;
  endtask

  // Every Regwrite pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (wbif.Regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_rd", 32'(wbif.write_register), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_rd",   32'(wbif.write_register), 32'(mon_e.rd));
        check("wb_data", wbif.write_data, mon_e.data);
      end
    end
  end

  initial begin
    idle();
    wbif.src_rs = '0;
    wbif.src_rt = '0;
    reset = 1'b0;
    tick();
    tick();
    check("rst_regwrite", 32'(wbif.Regwrite), 0);
    check("rst_wreg",     32'(wbif.write_register), 0);
    check("rst_wdata",    wbif.write_data, 0);
    check("rst_spurious", 32'(wbif.spurious_wb), 0);
    check("rst_mem_ready", 32'(wbif.mem_ready), 0);
    reset = 1'b1;
    #1;
    check("post_rst_mem_ready", 32'(wbif.mem_ready), 1);

    // Issue rd=8 then ALU writeback clears the hazard on the write edge.
    wbif.issue_valid = 1'b1; wbif.issue_rd = 5'd8;
    #1 check("t31_no_stall", 32'(wbif.issue_stall), 0);
    tick();
    wbif.issue_valid = 1'b0;
    wbif.src_rs = 5'd8;
    #1 check("t31_hazard_set", 32'(wbif.hazard), 1);
    wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd8; wbif.alu_data = 32'h1234;
    exp_q.push_back('{rd: 5'd8, data: 32'h1234});
    tick();
    idle();
    check("t31_regwrite", 32'(wbif.Regwrite), 1);
    check("t31_hazard_clr", 32'(wbif.hazard), 0);
    wbif.src_rs = '0;

    // WAW stall on a second issue to rd=9, accepted after writeback.
    issue(5'd9);
    wbif.issue_valid = 1'b1; wbif.issue_rd = 5'd9;
    #1 check("t32_stall", 32'(wbif.issue_stall), 1);
    tick();
    idle();
    wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd9; wbif.alu_data = 32'hA5A5_0009;
    exp_q.push_back('{rd: 5'd9, data: 32'hA5A5_0009});
    tick();
    idle();
    wbif.issue_valid = 1'b1; wbif.issue_rd = 5'd9;
    #1 check("t32_accept", 32'(wbif.issue_stall), 0);
    tick();
    idle();
    wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd9; wbif.alu_data = 32'h0000_0999;
    exp_q.push_back('{rd: 5'd9, data: 32'h0000_0999});
    tick();
    idle();
    check("t32_spurious_clean", 32'(wbif.spurious_wb), 0);

    // ALU held three cycles while two loads queue up; loads drain in order afterwards.
    issue(5'd20); issue(5'd21); issue(5'd22); issue(5'd10); issue(5'd11);
    exp_q.push_back('{rd: 5'd20, data: 32'h0000_0020});
    exp_q.push_back('{rd: 5'd21, data: 32'h0000_0021});
    exp_q.push_back('{rd: 5'd22, data: 32'h0000_0022});
    exp_q.push_back('{rd: 5'd10, data: 32'h0000_010A});
    exp_q.push_back('{rd: 5'd11, data: 32'h0000_011B});
    wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd20; wbif.alu_data = 32'h20;
    wbif.mem_valid = 1'b1; wbif.mem_rd = 5'd10; wbif.mem_data = 32'h10A;
    #1 check("t33_ready0", 32'(wbif.mem_ready), 1);
    tick();
    wbif.alu_rd = 5'd21; wbif.alu_data = 32'h21;
    wbif.mem_rd = 5'd11; wbif.mem_data = 32'h11B;
    #1 check("t33_ready1", 32'(wbif.mem_ready), 1);
    tick();
    wbif.alu_rd = 5'd22; wbif.alu_data = 32'h22;
    wbif.mem_rd = 5'd15; wbif.mem_data = 32'hDEAD_BEEF;
    #1 check("t33_full", 32'(wbif.mem_ready), 0);
    tick();
    idle();
    #1 check("t33_full_pop", 32'(wbif.mem_ready), 0);
    tick();
    check("t33_ready_again", 32'(wbif.mem_ready), 1);
    tick();
    tick();
    wbif.src_rs = 5'd10; wbif.src_rt = 5'd11;
    #1 check("t33_hazard_clr", 32'(wbif.hazard), 0);
    check("t33_queue_drained", exp_q.size(), 0);

    // Writes to r0 are consumed silently and r0 never looks busy.
    wbif.src_rs = '0; wbif.src_rt = '0;
    wbif.alu_valid = 1'b1; wbif.alu_rd = '0; wbif.alu_data = 32'hFFFF_FFFF;
    #1 check("t34_hazard_r0", 32'(wbif.hazard), 0);
    tick();
    idle();
    check("t34_no_write", 32'(wbif.Regwrite), 0);
    check("t34_no_spurious", 32'(wbif.spurious_wb), 0);

    // Result to non-pending r5 with a same-cycle issue to r5: written, flagged, and busy stays set.
    wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd5; wbif.alu_data = 32'h55;
    wbif.issue_valid = 1'b1; wbif.issue_rd = 5'd5;
    exp_q.push_back('{rd: 5'd5, data: 32'h55});
    #1 check("t35_no_stall", 32'(wbif.issue_stall), 0);
    tick();
    idle();
    wbif.src_rs = 5'd5;
    #1 check("t35_spurious", 32'(wbif.spurious_wb), 1);
    check("t35_set_wins", 32'(wbif.hazard), 1);
    tick();
    tick();
    check("t35_sticky", 32'(wbif.spurious_wb), 1);
    wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd5; wbif.alu_data = 32'h66;
    exp_q.push_back('{rd: 5'd5, data: 32'h66});
    tick();
    idle();
    check("t35_busy_clr", 32'(wbif.hazard), 0);
    check("t35_sticky2", 32'(wbif.spurious_wb), 1);

    // Fill the load buffer behind r0 ALU results, then reset for one cycle.
    issue(5'd24); issue(5'd25);
    wbif.alu_valid = 1'b1; wbif.alu_rd = '0; wbif.alu_data = 32'h1;
    wbif.mem_valid = 1'b1; wbif.mem_rd = 5'd24; wbif.mem_data = 32'h24;
    tick();
    wbif.mem_rd = 5'd25; wbif.mem_data = 32'h25;
    tick();
    idle();
    check("t36_full", 32'(wbif.mem_ready), 0);
    reset = 1'b0;
    #1 check("t36_ready_in_rst", 32'(wbif.mem_ready), 0);
    tick();
    reset = 1'b1;
    #1 check("t36_ready_after", 32'(wbif.mem_ready), 1);
    check("t36_no_write", 32'(wbif.Regwrite), 0);
    check("t36_spurious_clr", 32'(wbif.spurious_wb), 0);
    wbif.issue_valid = 1'b1; wbif.issue_rd = 5'd24;
    #1 check("t36_no_stall", 32'(wbif.issue_stall), 0);
    wbif.issue_valid = 1'b0;
    for (int i = 0; i < NUM_GPR; i++) begin
      wbif.src_rs = reg_addr_t'(i);
      wbif.src_rt = reg_addr_t'(i);
      #1 check($sformatf("t36_busy_%0d", i), 32'(wbif.hazard), 0);
    end
    tick();
    tick();
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_writeback.md
MIPS_CPU_WRITEBACK -- requirements
Module: mips_cpu_writeback

Interface
REQ-001 SHALL have parameter MEM_FIFO_DEPTH, default 2, giving the number of buffered load results (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port issue_valid  input  1  an instruction with a GPR destination is issuing this cycle.
REQ-005 SHALL have port issue_rd  input  5  destination GPR index of the issuing instruction.
REQ-006 SHALL have port issue_stall  output  1  issue must hold: issue_rd is already pending (WAW).
REQ-007 SHALL have ports src_rs, src_rt  input  5 each  source GPR indices of the decoding instruction.
REQ-008 SHALL have port hazard  output  1  a source GPR has a pending write (RAW).
REQ-009 SHALL have ports alu_valid (1), alu_rd (5), alu_data (32)  input  ALU result, always accepted.
REQ-010 SHALL have ports mem_valid (1), mem_rd (5), mem_data (32)  input  load result; mem_ready  output  1  load result accepted.
REQ-011 SHALL have ports Regwrite (1), write_register (5), write_data (32)  output  register-file write port.
REQ-012 SHALL have port spurious_wb  output  1  sticky: a result arrived for a non-pending nonzero GPR.

Function
REQ-013 SHALL keep a 32-bit busy scoreboard; busy[0] is constant 0.
REQ-014 issue_stall SHALL be combinational: issue_valid & busy[issue_rd].
REQ-015 On issue_valid & !issue_stall & issue_rd!=0, busy[issue_rd] SHALL be set at the next edge.
REQ-016 hazard SHALL be combinational: busy[src_rs] | busy[src_rt].
REQ-017 mem_ready SHALL be !fifo_full (independent of same-cycle pop); a load result SHALL be pushed on mem_valid & mem_ready.
REQ-018 Each cycle SHALL select one writeback: alu_valid wins; otherwise FIFO head if non-empty (popped that cycle); otherwise none.
REQ-019 Write port outputs SHALL be registered: selected result appears on Regwrite/write_register/write_data exactly 1 cycle after selection.
REQ-020 A selected result with rd=0 SHALL be consumed with Regwrite=0 on the output cycle.
REQ-021 busy[rd] SHALL clear at the edge that registers the selected writeback (same edge Regwrite rises).
REQ-022 Set and clear of the same index at one edge SHALL resolve to set (clear of old writer, set of new issue).
REQ-023 A selected result with rd!=0 and busy[rd]=0 SHALL still be written and SHALL set spurious_wb until reset.
REQ-024 FIFO SHALL preserve load order; simultaneous push and pop SHALL keep occupancy unchanged; wrap-around of pointers SHALL be modulo MEM_FIFO_DEPTH.
REQ-025 ALU priority SHALL be able to starve the FIFO indefinitely; no fairness required.

Reset
REQ-026 While reset=0 at a posedge: busy=0, FIFO empty, Regwrite=0, write_register=0, write_data=0, spurious_wb=0.
REQ-027 During reset mem_ready SHALL be 0 and issue/result inputs SHALL be ignored; mem_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight results without any Regwrite pulse.

Structure
REQ-029 Package mips_cpu_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_GPR=32 and typedef wb_entry_t {rd, data}.
REQ-030 The load buffer SHALL be sub-module mips_cpu_wb_fifo (wb_entry_t payload, full/empty flags); scoreboard and arbitration stay in the top module.

Verification
REQ-031 Issue rd=8, then alu_valid rd=8 data=0x1234 -> next cycle Regwrite=1, write_register=8, write_data=0x1234; busy[8] and hazard (src_rs=8) clear same edge.
REQ-032 Issue rd=9, then issue rd=9 again before writeback -> issue_stall=1 on second issue; after writeback, issue accepted.
REQ-033 Pending rd=10,11; mem results 10 then 11 while alu_valid held 3 cycles -> mem_ready=0 after 2 pushes, ALU writes first, then 10, then 11 in order.
REQ-034 alu_valid rd=0 data=0xFFFFFFFF -> Regwrite stays 0, spurious_wb stays 0; hazard with src_rs=0 always 0.
REQ-035 alu result to non-pending rd=5 -> written, spurious_wb=1 and held until reset.
REQ-036 Fill FIFO, assert reset=0 one cycle -> no Regwrite pulse, busy all 0, mem_ready=1 the cycle after reset returns to 1.
